// File: rtl/alu_exec_unit.sv
// EX-stage execute unit: RV32I (+ optional M) ALU decode and datapath with a
// registered result and an iterative radix-2 restoring divider.
module alu_exec_unit #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_b5,
    input  logic            funct7_b0,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIV_RUN  = 2'd1,
        S_DIV_DONE = 2'd2
    } state_t;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILLEGAL
    } op_t;

    // Handshake: an op is taken on a rising edge where in_valid & in_ready & !flush;
    // in_ready depends only on state; out_valid is a single-cycle pulse per result.

    state_t state, state_next;
    op_t    op;

    logic            accept;
    logic            div_start;
    logic            step_en;
    logic            done_fire;
    logic [XLEN-1:0] alu_res;

    // Divider state
    logic [XLEN-1:0] div_rem;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_dvs;
    logic [SHW-1:0]  div_cnt;
    logic            neg_q;
    logic            neg_r;
    logic            want_rem;

    function automatic op_t decode_base(input logic [2:0] f3, input logic b5, input logic imm);
        op_t o;
        o = OP_ILLEGAL;
        case (f3)
            3'b000: o = (!imm && b5) ? OP_SUB : OP_ADD;
            3'b101: o = b5 ? OP_SRA : OP_SRL;
            default: begin
                if (imm || !b5) begin
                    case (f3)
                        3'b001:  o = OP_SLL;
                        3'b010:  o = OP_SLT;
                        3'b011:  o = OP_SLTU;
                        3'b100:  o = OP_XOR;
                        3'b110:  o = OP_OR;
                        3'b111:  o = OP_AND;
                        default: o = OP_ILLEGAL;
                    endcase
                end
            end
        endcase
        return o;
    endfunction

    function automatic op_t decode_m(input logic [2:0] f3);
        op_t o;
        case (f3)
            3'b000:  o = OP_MUL;
            3'b001:  o = OP_MULH;
            3'b010:  o = OP_MULHSU;
            3'b011:  o = OP_MULHU;
            3'b100:  o = OP_DIV;
            3'b101:  o = OP_DIVU;
            3'b110:  o = OP_REM;
            default: o = OP_REMU;
        endcase
        return o;
    endfunction

    always_comb begin
        op = OP_ILLEGAL;
        case (alu_op)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                if (!funct7_b0) begin
                    op = decode_base(funct3, funct7_b5, 1'b0);
                end else if (ENABLE_M) begin
                    op = decode_m(funct3);
                end
            end
            default: op = decode_base(funct3, funct7_b5, 1'b1);
        endcase
    end

    // Single-cycle datapath
    logic [SHW-1:0]    shamt;
    logic [2*XLEN-1:0] ext_a;
    logic [2*XLEN-1:0] ext_b;
    logic [2*XLEN-1:0] prod;
    logic              is_div;
    logic              div_signed;
    logic              is_rem;
    logic              b_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   div_special;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;

    always_comb begin
        shamt      = operand_b[SHW-1:0];
        ext_a      = {{XLEN{(op == OP_MULH || op == OP_MULHSU) & operand_a[XLEN-1]}}, operand_a};
        ext_b      = {{XLEN{(op == OP_MULH) & operand_b[XLEN-1]}}, operand_b};
        prod       = ext_a * ext_b;
        is_div     = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
        div_signed = (op == OP_DIV) || (op == OP_REM);
        is_rem     = (op == OP_REM) || (op == OP_REMU);
        b_zero     = (operand_b == '0);
        div_ovf    = div_signed && (operand_a == MOST_NEG) && (operand_b == '1);
        if (b_zero) begin
            div_special = is_rem ? operand_a : '1;
        end else begin
            div_special = is_rem ? '0 : MOST_NEG;
        end
        mag_a = (div_signed && operand_a[XLEN-1]) ? -operand_a : operand_a;
        mag_b = (div_signed && operand_b[XLEN-1]) ? -operand_b : operand_b;

        alu_res = '0;
        case (op)
            OP_ADD:    alu_res = operand_a + operand_b;
            OP_SUB:    alu_res = operand_a - operand_b;
            OP_SLL:    alu_res = operand_a << shamt;
            OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            OP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            OP_XOR:    alu_res = operand_a ^ operand_b;
            OP_SRL:    alu_res = operand_a >> shamt;
            OP_SRA:    alu_res = $unsigned($signed(operand_a) >>> shamt);
            OP_OR:     alu_res = operand_a | operand_b;
            OP_AND:    alu_res = operand_a & operand_b;
            OP_MUL:    alu_res = prod[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  alu_res = prod[2*XLEN-1:XLEN];
            OP_DIV,
            OP_DIVU,
            OP_REM,
            OP_REMU:   alu_res = div_special;
            default:   alu_res = '0;
        endcase
    end

    assign accept    = in_valid && in_ready && !flush;
    assign div_start = accept && is_div && !b_zero && !div_ovf;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (div_start) state_next = S_DIV_RUN;
            S_DIV_RUN: begin
                if (flush) begin
                    state_next = S_IDLE;
                end else if (div_cnt == '0) begin
                    state_next = S_DIV_DONE;
                end
            end
            S_DIV_DONE: state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state == S_IDLE);
        step_en   = (state == S_DIV_RUN) && !flush;
        done_fire = (state == S_DIV_DONE) && !flush;
    end

    // One restoring step: shift next dividend bit into the partial remainder.
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] quo_final;
    logic [XLEN-1:0] rem_final;
    logic [XLEN-1:0] div_final;

    always_comb begin
        shifted   = {div_rem, div_quo[XLEN-1]};
        trial     = shifted - {1'b0, div_dvs};
        quo_final = neg_q ? -div_quo : div_quo;
        rem_final = neg_r ? -div_rem : div_rem;
        div_final = want_rem ? rem_final : quo_final;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            div_rem   <= '0;
            div_quo   <= '0;
            div_dvs   <= '0;
            div_cnt   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            want_rem  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !div_start) begin
                result    <= alu_res;
                zero      <= (alu_res == '0);
                illegal   <= (op == OP_ILLEGAL);
                out_valid <= 1'b1;
            end
            if (div_start) begin
                div_rem  <= '0;
                div_quo  <= mag_a;
                div_dvs  <= mag_b;
                div_cnt  <= SHW'(XLEN - 1);
                neg_q    <= div_signed && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
                neg_r    <= div_signed && operand_a[XLEN-1];
                want_rem <= is_rem;
            end
            if (step_en) begin
                if (!trial[XLEN]) begin
                    div_rem <= trial[XLEN-1:0];
                    div_quo <= {div_quo[XLEN-2:0], 1'b1};
                end else begin
                    div_rem <= shifted[XLEN-1:0];
                    div_quo <= {div_quo[XLEN-2:0], 1'b0};
                end
                div_cnt <= div_cnt - SHW'(1);
            end
            if (done_fire) begin
                result    <= div_final;
                zero      <= (div_final == '0);
                illegal   <= 1'b0;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised EX-stage execute unit. It merges ALU-control decode and the datapath. It fully decodes ALUOp/funct3/funct7 for RV32I ALU ops and, optionally, the M extension. Single-cycle ops return a registered result after 1 cycle; DIV/REM run on an iterative radix-2 divider over XLEN cycles. A valid/ready handshake stalls the pipeline while the divider is busy, and a flush input squashes in-flight work.

Parameters:
XLEN, 32, operand/result width (power of 2, ≥8)
ENABLE_M, 1, 1 = decode MUL/DIV/REM; 0 = those encodings are illegal

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operation presented this cycle
in_ready  out  1  unit can accept; op accepted on edge where in_valid & in_ready & !flush
alu_op  in  2  00 add (ld/st addr), 01 sub (branch), 10 R-type, 11 I-type ALU
funct3  in  3  instruction funct3
funct7_b5  in  1  instruction bit 30 (sub/sra select)
funct7_b0  in  1  instruction bit 25 (M-extension select)
operand_a  in  XLEN  rs1 value
operand_b  in  XLEN  rs2 value or immediate
flush  in  1  squash accepted/in-flight op
out_valid  out  1  one-cycle pulse: result/zero/illegal valid
result  out  XLEN  registered result
zero  out  1  registered (result == 0)
illegal  out  1  registered: accepted encoding undefined

Behaviour:
- Reset: state IDLE; out_valid=0, result=0, zero=0, illegal=0; divider regs cleared; in_ready=1 from the first cycle after reset deasserts. Reset overrides everything, including a mid-divide operation (no out_valid).
- in_ready = (state==IDLE). Combinational; it must not depend on in_valid.
- Decode, fully specified with no hold/latch on unlisted codes:
  - alu_op 00 → ADD. alu_op 01 → SUB.
  - alu_op 10, funct7_b0=0, by funct3:
    - 000: ADD if funct7_b5=0, SUB if 1
    - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND (each requires funct7_b5=0)
    - 101: SRL if funct7_b5=0, SRA if 1
  - alu_op 11: same as alu_op 10 except funct3=000 is always ADD (funct7_b5 ignored); funct7_b5 is checked only for 101.
  - alu_op 10, funct7_b0=1, ENABLE_M=1, by funct3:
    - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
    - 100 DIV, 101 DIVU, 110 REM, 111 REMU
  - Any other combination → illegal=1, result=0, out_valid pulses with latency 1.
- Shift amount = operand_b[$clog2(XLEN)-1:0]. SRA sign-fills. SLT/SLTU produce 0/1 zero-extended.
- MULH* return the upper XLEN bits of the 2·XLEN product, signed per RISC-V.
- Latency 1 (all non-divide ops, plus divide special cases): op accepted on edge E; result registered on edge E; out_valid high for the cycle after E only. Back-to-back accepts give out_valid every cycle.
- Divide FSM:
  - IDLE → DIV_RUN on accept of a DIV/DIVU/REM/REMU that is not a special case. Operands are converted to magnitudes and signs are latched.
  - DIV_RUN: one restoring-division step per edge; XLEN steps; counter counts XLEN-1 down to 0.
  - DIV_RUN → DIV_DONE after the last step.
  - DIV_DONE: apply sign correction, register result, out_valid=1 next cycle, → IDLE.
  - Result is registered on edge E+XLEN+1, giving latency XLEN+1. in_ready is low for XLEN+1 cycles.
  - Quotient sign = sign_a XOR sign_b (signed ops). Remainder takes sign of dividend.
- Divide special cases complete with latency 1 and never enter DIV_RUN:
  - b==0: DIV/DIVU → all ones; REM/REMU → operand_a.
  - Signed overflow (a = most-negative, b = −1): DIV → most-negative; REM → 0.
- flush:
  - In IDLE with in_valid: op not accepted.
  - Same edge as a latency-1 result: that out_valid is suppressed.
  - In DIV_RUN/DIV_DONE: → IDLE, no out_valid, result/zero retain previous values.
  - in_ready=1 the cycle after flush.
- result/zero/illegal hold their values while out_valid=0.

Test Plan:
1. Reset 2 cycles, then alu_op=10 f3=000 f7b5=0, a=5, b=7 → next cycle out_valid=1, result=12, zero=0, illegal=0; out_valid=0 the cycle after.
2. alu_op=01, a=9, b=9 → result=0, zero=1. alu_op=11 f3=101 f7b5=1 (SRAI), a=0x80000000, b=4 → 0xF8000000. Same with f7b5=0 (SRLI) → 0x08000000.
3. DIV a=−20, b=3, in_valid held with a following ADD 1+1 → in_ready low 33 cycles; out_valid exactly 33 cycles after accept with result 0xFFFFFFFA; ADD accepted on the first in_ready=1 cycle, result 2 one cycle later. Repeat with REM → 0xFFFFFFFE.
4. DIVU 7/0 → 0xFFFFFFFF at latency 1; REM 7/0 → 7; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of same → 0, zero=1; in_ready never drops.
5. MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. With ENABLE_M=0, any funct7_b0=1 R-type → illegal=1, result=0.
6. Flush on the 10th cycle of a DIV → no out_valid, in_ready=1 next cycle, result unchanged. Reset asserted mid-DIV → all outputs 0, in_ready=1 after release.
